mips_irq_ctl: RTL
=================

# mips_irq_ctl

Parametrised memory-mapped interrupt controller for the MIPS789 device bus; successor to the fixed three-source interrupt logic in the device controller. It synchronises NSRC external or internal request lines, latches them as edge- or level-triggered pending bits, masks them, and selects the highest-priority source. It presents that source's programmable vector on `irq_addr_o` with a request/acknowledge handshake to the core. It sits on the same `din`/`addr`/`mem_ctl`/`dout` data-memory bus as the other devices; its `dout` is OR-ed into the device read mux.

## Interface
- `NSRC`, 4: number of interrupt sources, 1..16.
- `BASE_ADDR`, 32'h0000_8000: byte address of register 0, word aligned.
- `SYNC_STAGES`, 2: synchroniser flops per source, at least 2.

Clock and reset are one clock, `clk`, and reset `rst`, which is asynchronous and active-low.

- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `din` input 32: write data.
- `addr` input 32: byte address, full 32-bit compare.
- `mem_ctl` input 4: access code. Only `` `DMEM_SW `` (write) and `` `DMEM_LW `` (read) decode; all other codes are ignored.
- `dout` output 32: registered read data; 0 when not reading this block.
- `irq_src_i` input NSRC: raw request lines, asynchronous to `clk`.
- `irq_ack_i` input 1: single-cycle acknowledge from the core.
- `irq_req_o` output 1: registered interrupt request.
- `irq_addr_o` output 32: registered vector of the source being requested.
- `irq_id_o` output 4: registered index of the source being requested.

## Operation
The register map uses byte offsets from `BASE_ADDR`:
- 0x00 ENABLE: read/write, bits [NSRC-1:0].
- 0x04 PENDING: read. A write-1 clears a bit, but only for edge-mode sources.
- 0x08 MODE: read/write. 1 = rising-edge, 0 = level (high).
- 0x0C STATUS: read-only. Bit 31 = `irq_req_o`, [3:0] = `irq_id_o`.
- 0x10+4*i VECTOR[i], for i < NSRC: read/write, 32 bits.
- Unused bits read 0. Accesses to unmapped offsets are ignored and read 0.

Source path:
- Each `irq_src_i[i]` passes through SYNC_STAGES flops. One further flop gives the rising-edge detect.
- Edge mode: pending[i] is set on a detected rising edge. It clears on W1C or on acknowledge of source i.
- Level mode: pending[i] equals the synchronised level. W1C and acknowledge have no effect on it.
- Conflicts: a set event and a clear event in the same cycle resolve as set.

Request state machine:
- IDLE: when `|(pending & enable)` is true, capture the lowest set index as `irq_id_o`, load `irq_addr_o` = VECTOR[id], assert `irq_req_o`, and go to REQ.
- REQ: the request is held, with id and vector stable, until `irq_ack_i` arrives. The request is not retracted if the source is disabled or cleared meanwhile.
  - On `irq_ack_i`: deassert `irq_req_o`, clear pending[id] if edge mode, and go to GAP.
- GAP: one cycle with `irq_req_o` low, then go to IDLE.
- `irq_ack_i` outside REQ is ignored.
- A VECTOR write to the active id during REQ does not change `irq_addr_o`.

## Timing
- Reset values: `dout`=0, `irq_req_o`=0, `irq_addr_o`=0, `irq_id_o`=0. ENABLE, PENDING, MODE and all VECTORs are 0, the synchroniser and edge flops are 0, and the state is IDLE.
- Reset asserted mid-request drops `irq_req_o` asynchronously.
- Register write: the new value is visible on the edge following the access cycle.
- Register read: `dout` is valid on the edge after the access cycle (1-cycle latency). `dout` is 0 on every other cycle.
- Source to pending: a rising edge on `irq_src_i` sets pending SYNC_STAGES+1 clocks later.
- Pending to request: `irq_req_o` rises 1 clock after pending&enable becomes true.
- Acknowledge to release: `irq_req_o` falls on the clock after `irq_ack_i` is sampled high.
- Back-to-back requests are separated by at least 1 low cycle.

## Configuration
Macro: `MIPS_IRQ_PREEMPT_EN`.
- Defined: while in REQ, if a lower-index source becomes pending&enabled, `irq_id_o` and `irq_addr_o` update to it on the next clock. `irq_req_o` stays high throughout, and the displaced source stays pending. If the core acks in the same cycle as a preemption, the ack applies to the old id and the state goes to GAP.
- Undefined: the request is frozen in REQ as described under Operation, and no preemption occurs.

## Test plan
- **Reset and readback:** hold `rst`=0 and check all outputs are 0. Then write VECTOR[2]=32'h0000_0200, ENABLE=4'hF, MODE=4'hF, and read each back. `dout` must match one cycle after each read.
- **Edge-mode request:** pulse `irq_src_i[2]` high for 1 clock.
  - `irq_req_o` must rise SYNC_STAGES+2 clocks later, with `irq_addr_o`=32'h200 and `irq_id_o`=2.
  - Ack: `irq_req_o` must fall next clock and PENDING must read 0.
- **Priority:** pending sources 1 and 3 in the same cycle must request id 1 first. After ack and the gap cycle, id 3 must follow.
- **Level mode and masking:** with MODE[0]=0 and `irq_src_i[0]` held high but ENABLE[0]=0, there is no request. Setting ENABLE[0]=1 must produce a request. After ack with the source still high, the request must re-assert after the 1-cycle gap. Writing W1C to PENDING[0] must not clear it.
- **Simultaneous events:** an edge on source 2 in the same cycle as its ack, or as a W1C write to PENDING[2], must leave PENDING[2]=1. An ack sampled in IDLE must be ignored.
- **Preemption:** with `MIPS_IRQ_PREEMPT_EN` defined, raise source 0 while id 3 is being requested. `irq_id_o` must become 0 the next clock without `irq_req_o` dropping. Without the macro, id must stay 3 until ack.

Source files
------------

// File: rtl/mips_irq_ctl.sv
// Interrupt controller: sync, edge/level pending latch, mask, lowest-index priority, vector handshake.
// Latency: src edge -> pending SYNC_STAGES+1 clks, pending -> irq_req_o 1 clk, register read 1 clk.
// Backpressure: a request is held until irq_ack_i, then one GAP cycle before the next request.
//
// Ports:
//   clk, rst        - single rising-edge clock, asynchronous active-low reset
//   din/addr/mem_ctl - device-bus write data, byte address, access code (DMEM_SW / DMEM_LW)
//   dout            - registered read data, 0 when this block is not being read
//   irq_src_i       - raw request lines, asynchronous to clk
//   irq_ack_i       - single-cycle acknowledge from the core
//   irq_req_o/irq_addr_o/irq_id_o - registered request, vector and source index
//
// Optional feature macro: MIPS_IRQ_PREEMPT_EN (lower-index source displaces the active request).

`ifndef DMEM_LW
`define DMEM_LW 4'h1
`endif
`ifndef DMEM_SW
`define DMEM_SW 4'h2
`endif

module mips_irq_ctl #(
  parameter int          NSRC        = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_8000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     din,
  input  logic [31:0]     addr,
  input  logic [3:0]      mem_ctl,
  output logic [31:0]     dout,
  input  logic [NSRC-1:0] irq_src_i,
  input  logic            irq_ack_i,
  output logic            irq_req_o,
  output logic [31:0]     irq_addr_o,
  output logic [3:0]      irq_id_o
);

  localparam logic [31:0] VEC_END = 32'h10 + 32'(4 * NSRC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t          state;
  logic [NSRC-1:0] enable_q;
  logic [NSRC-1:0] mode_q;
  logic [NSRC-1:0] pending_q;
  logic [31:0]     vector_q [NSRC];
  logic [NSRC-1:0] sync_q   [SYNC_STAGES];
  logic [NSRC-1:0] edge_q;

  // ---------------- bus decode ----------------
  logic [31:0] offset;
  logic        wr_en, rd_en;
  logic        hit_enable, hit_pending, hit_mode, hit_status, vec_hit;
  logic [5:0]  vec_word;

  assign offset      = addr - BASE_ADDR;
  assign wr_en       = (mem_ctl == `DMEM_SW);
  assign rd_en       = (mem_ctl == `DMEM_LW);
  assign hit_enable  = (offset == 32'h00);
  assign hit_pending = (offset == 32'h04);
  assign hit_mode    = (offset == 32'h08);
  assign hit_status  = (offset == 32'h0C);
  // Addresses below BASE_ADDR wrap to huge offsets and fall outside this window.
  assign vec_hit     = (offset >= 32'h10) && (offset < VEC_END) && (offset[1:0] == 2'b00);
  assign vec_word    = offset[7:2] - 6'd4;

  // ---------------- source path ----------------
  logic [NSRC-1:0] sync_lvl;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] w1c;
  logic [NSRC-1:0] ack_clr;
  logic [NSRC-1:0] active;

  assign sync_lvl = sync_q[SYNC_STAGES-1];
  assign rise     = sync_lvl & ~edge_q;
  assign w1c      = (wr_en && hit_pending) ? din[NSRC-1:0] : '0;
  assign active   = pending_q & enable_q;

  // Acknowledge always refers to the id currently on irq_id_o, even if a
  // preemption would otherwise have retargeted it this cycle.
  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NSRC; i++) begin
      ack_clr[i] = (state == REQ) && irq_ack_i && (irq_id_o == i[3:0]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      edge_q <= '0;
    end else begin
      sync_q[0] <= irq_src_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      edge_q <= sync_lvl;
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable_q  <= '0;
      mode_q    <= '0;
      pending_q <= '0;
      for (int i = 0; i < NSRC; i++) vector_q[i] <= '0;
    end else begin
      if (wr_en && hit_enable) enable_q <= din[NSRC-1:0];
      if (wr_en && hit_mode)   mode_q   <= din[NSRC-1:0];
      for (int i = 0; i < NSRC; i++) begin
        if (wr_en && vec_hit && (vec_word == i[5:0])) vector_q[i] <= din;
        // Edge mode: a set in the same cycle as a clear wins.
        // Level mode: pending simply tracks the synchronised line.
        if (mode_q[i])
          pending_q[i] <= rise[i] | (pending_q[i] & ~(w1c[i] | ack_clr[i]));
        else
          pending_q[i] <= sync_lvl[i];
      end
    end
  end

  // ---------------- read path ----------------
  logic [31:0] rdata;

  always_comb begin
    rdata = 32'h0;
    if (hit_enable)  rdata = {{(32-NSRC){1'b0}}, enable_q};
    if (hit_pending) rdata = {{(32-NSRC){1'b0}}, pending_q};
    if (hit_mode)    rdata = {{(32-NSRC){1'b0}}, mode_q};
    if (hit_status)  rdata = {irq_req_o, 27'd0, irq_id_o};
    for (int i = 0; i < NSRC; i++) begin
      if (vec_hit && (vec_word == i[5:0])) rdata = vector_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dout <= 32'h0;
    else      dout <= rd_en ? rdata : 32'h0;
  end

  // ---------------- priority select ----------------
  function automatic logic [3:0] lowest(input logic [NSRC-1:0] v);
    lowest = 4'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) lowest = i[3:0];
    end
  endfunction

  logic [3:0]  pick;
  logic [31:0] pick_vec;

  assign pick = lowest(active);

  always_comb begin
    pick_vec = 32'h0;
    for (int i = 0; i < NSRC; i++) begin
      if (pick == i[3:0]) pick_vec = vector_q[i];
    end
  end

  // ---------------- request FSM ----------------
  // The vector is captured at request time, so later VECTOR writes do not
  // disturb irq_addr_o while the core is servicing it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      irq_req_o  <= 1'b0;
      irq_id_o   <= 4'd0;
      irq_addr_o <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (|active) begin
            irq_id_o   <= pick;
            irq_addr_o <= pick_vec;
            irq_req_o  <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (irq_ack_i) begin
            irq_req_o <= 1'b0;
            state     <= GAP;
          end
`ifdef MIPS_IRQ_PREEMPT_EN
          else if ((|active) && (pick < irq_id_o)) begin
            // Displaced source keeps its pending bit and is served later.
            irq_id_o   <= pick;
            irq_addr_o <= pick_vec;
          end
`endif
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
